// File: rtl/sseg_scan_display.sv
// sseg_scan_display: double-buffered N-digit hex scanner for 7-seg displays; SSEG_DIM_EN adds brightness PWM
module sseg_scan_display #(
  parameter int N_DIGITS      = 4,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_val,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_load,
  input  logic                  i_lz_blank,
  input  logic [3:0]            i_bright,
  output logic [7:0]            o_sseg_n,
  output logic [N_DIGITS-1:0]   o_ldsel,
  output logic                  o_frame
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  logic [PRESCALE_BITS-1:0] presc;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] act_val, pend_val;
  logic [N_DIGITS-1:0] act_dp, pend_dp;
  logic pend;
  logic wrap, boundary, blank, on;
  logic [3:0] nib;
  logic [6:0] seg;
  assign wrap = &presc;
  assign boundary = wrap && idx == LAST;
  assign nib = 4'(act_val >> {idx, 2'b00});
  // a digit blanks when it and every digit above it hold zero
  assign blank = i_lz_blank && idx != '0 && (act_val >> {idx, 2'b00}) == '0;
`ifdef SSEG_DIM_EN
  assign on = presc != '0 && presc[PRESCALE_BITS-1 -: 4] <= i_bright;
`else
  logic unused_bright;
  assign unused_bright = ^i_bright;
  assign on = presc != '0;
`endif
  always_comb begin
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc    <= '0;
      idx      <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend     <= 1'b0;
      o_sseg_n <= 8'hFF;
      o_ldsel  <= '1;
      o_frame  <= 1'b0;
    end else begin
      presc   <= presc + 1'b1;
      o_frame <= boundary;
      if (wrap) idx <= idx == LAST ? '0 : idx + 1'b1;
      // a load on the boundary itself bypasses the pending stage
      if (boundary && i_load) begin
        act_val <= i_val;
        act_dp  <= i_dp;
        pend    <= 1'b0;
      end else if (i_load) begin
        pend_val <= i_val;
        pend_dp  <= i_dp;
        pend     <= 1'b1;
      end else if (boundary && pend) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        pend    <= 1'b0;
      end
      o_sseg_n <= blank ? 8'hFF : {~act_dp[idx], seg};
      o_ldsel  <= on ? ~(N_DIGITS'(1) << idx) : '1;
    end
  end
endmodule

// File: tb/tb_sseg_scan_display.sv
// tb_sseg_scan_display: directed scoreboard bench for sseg_scan_display (N_DIGITS=4, PRESCALE_BITS=4)
module tb_sseg_scan_display;
  localparam int N = 4;
  localparam int PB = 4;
`ifdef SSEG_DIM_EN
  localparam int ON_EXP = 3;
`else
  localparam int ON_EXP = 15;
`endif
  typedef struct packed {
    logic [7:0] s;
    logic [3:0] l;
  } exp_t;
  logic clk = 1'b0;
  logic i_reset, i_load, i_lz_blank;
  logic [15:0] i_val;
  logic [3:0] i_dp, i_bright;
  logic [7:0] o_sseg_n;
  logic [3:0] o_ldsel;
  logic o_frame;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  sseg_scan_display #(.N_DIGITS(N), .PRESCALE_BITS(PB)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_val(i_val), .i_dp(i_dp), .i_load(i_load),
    .i_lz_blank(i_lz_blank), .i_bright(i_bright), .o_sseg_n(o_sseg_n),
    .o_ldsel(o_ldsel), .o_frame(o_frame)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic lz);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.s = (lz && k > 0 && (v >> (4 * k)) == 16'h0) ? 8'hFF : {~d[k], seg_tab[v[4*k +: 4]]};
      e.l = sel_tab[k];
      sb.push_back(e);
    end
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      i_load = 1'b0;
      n++;
    end while (o_frame !== 1'b1 && n < 200);
    check("frame_seen", 8'(o_frame), 8'h01);
  endtask
  task automatic run_frame(input int lj1, input logic [15:0] v1, input logic [3:0] d1,
                           input int lj2, input logic [15:0] v2, input logic [3:0] d2);
    int on_cnt = 0;
    exp_t e;
    wait_frame();
    for (int j = 1; j < 64; j++) begin
      @(negedge clk);
      i_load = 1'b0;
      if (j <= 16 && o_ldsel != 4'hF) on_cnt++;
      if (j == 1) check("frame_pulse_width", 8'(o_frame), 8'h00);
      if (j % 16 == 1) check("ghost_guard", 8'(o_ldsel), 8'h0F);
      if (j == 16) check("on_time", 8'(on_cnt), 8'(ON_EXP));
      if (j % 16 == 3) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", 8'h01, 8'h00);
        end else begin
          e = sb.pop_front();
          check("sseg", o_sseg_n, e.s);
          check("ldsel", 8'(o_ldsel), 8'(e.l));
        end
      end
      if (j == lj1) begin
        i_val = v1;
        i_dp = d1;
        i_load = 1'b1;
      end
      if (j == lj2) begin
        i_val = v2;
        i_dp = d2;
        i_load = 1'b1;
      end
    end
  endtask
  initial begin
    i_reset = 1'b1;
    i_load = 1'b0;
    i_val = '0;
    i_dp = '0;
    i_lz_blank = 1'b0;
    i_bright = 4'd3;
    repeat (3) @(negedge clk);
    check("rst_sseg", o_sseg_n, 8'hFF);
    check("rst_ldsel", 8'(o_ldsel), 8'h0F);
    check("rst_frame", 8'(o_frame), 8'h00);
    // load under reset must be discarded
    i_val = 16'hFFFF;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    i_reset = 1'b0;
    @(negedge clk);
    check("post_rst_ghost", 8'(o_ldsel), 8'h0F);
    @(negedge clk);
    check("first_sel", 8'(o_ldsel), 8'h0E);
    check("first_seg", o_sseg_n, 8'hC0);
    i_val = 16'h12AF;
    i_dp = 4'b0000;
    i_load = 1'b1;
    push_frame(16'h12AF, 4'b0000, 1'b0);
    run_frame(0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // two loads in one frame: old value held, last load wins next frame
    push_frame(16'h12AF, 4'b0000, 1'b0);
    run_frame(4, 16'h0000, 4'h0, 30, 16'h1234, 4'h0);
    push_frame(16'h1234, 4'b0000, 1'b0);
    run_frame(0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // pending 5678 then a boundary load of 9ABC: 9ABC sticks, 5678 never shows
    push_frame(16'h1234, 4'b0000, 1'b0);
    run_frame(20, 16'h5678, 4'h0, 63, 16'h9ABC, 4'h0);
    push_frame(16'h9ABC, 4'b0000, 1'b0);
    run_frame(0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    i_lz_blank = 1'b1;
    push_frame(16'h9ABC, 4'b0000, 1'b1);
    run_frame(5, 16'h0050, 4'b1000, 0, 16'h0, 4'h0);
    push_frame(16'h0050, 4'b1000, 1'b1);
    run_frame(7, 16'h1050, 4'b1001, 0, 16'h0, 4'h0);
    push_frame(16'h1050, 4'b1001, 1'b1);
    run_frame(0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // mid-frame reset after a pending load
    i_lz_blank = 1'b0;
    wait_frame();
    repeat (5) @(negedge clk);
    i_val = 16'h7777;
    i_dp = 4'hF;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    repeat (10) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("midrst_sseg", o_sseg_n, 8'hFF);
    check("midrst_ldsel", 8'(o_ldsel), 8'h0F);
    check("midrst_frame", 8'(o_frame), 8'h00);
    i_reset = 1'b0;
    @(negedge clk);
    check("midrst_ghost", 8'(o_ldsel), 8'h0F);
    @(negedge clk);
    check("midrst_first_sel", 8'(o_ldsel), 8'h0E);
    check("midrst_first_seg", o_sseg_n, 8'hC0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    run_frame(0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
